// File: rtl/e_digit_stream.sv
// Streams the decimal expansion of a fixed-point value (8-bit integer part, 392-bit fraction)
// one BCD digit per valid/ready handshake, integer digit first, then NDIGITS fractional digits.
module e_digit_stream #(
    parameter int NDIGITS = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [399:0] ans,
    output logic         busy,
    output logic         digit_valid,
    input  logic         digit_ready,
    output logic [3:0]   digit,
    output logic [7:0]   digit_idx,
    output logic         last,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NDIGITS);

    state_t         state_q;
    logic [3:0]     int_q;
    logic [391:0]   frac_q;
    logic [7:0]     idx_q;
    logic           err_q;

    logic [395:0]   prod;
    logic [391:0]   frac_d;
    logic           int_ok;

    // The top nibble of frac*10 is the next decimal digit; the remainder is the next fraction.
    always_comb begin
        prod   = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);
        frac_d = prod[391:0];
        int_ok = (ans[399:392] <= 8'd9);
    end

    // NOTE: synchronous reset is tested inside the clocked block, so it outranks start and
    // digit_ready; all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            int_q   <= '0;
            frac_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        int_q   <= ans[395:392];
                        frac_q  <= ans[391:0];
                        idx_q   <= '0;
                        err_q   <= !int_ok;
                        state_q <= int_ok ? EMIT : FIN;
                    end
                end
                EMIT: begin
                    if (digit_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= FIN;
                        end else begin
                            // The integer digit consumes no fraction bits.
                            if (idx_q != 8'd0) frac_q <= frac_d;
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        digit_valid = (state_q == EMIT);
        busy        = (state_q == EMIT);
        done        = (state_q == FIN);
        err         = err_q;
        digit_idx   = idx_q;
        last        = (state_q == EMIT) && (idx_q == LAST_IDX);
        digit       = 4'd0;
        if (state_q == EMIT) digit = (idx_q == 8'd0) ? int_q : prod[395:392];
    end

endmodule

// File: tb/tb_e_digit_stream.sv
// Directed bench for e_digit_stream: table of operands with hand-computed leading digits,
// an independent multiply-by-ten model for the full digit stream, plus reset and start corner cases.
module tb_e_digit_stream;

    localparam int NDIGITS = 100;
    localparam int BUDGET  = 3000;

    typedef struct {
        logic [399:0] ans;
        logic [51:0]  hand;
        bit           exp_err;
        bit           bp;
        bit           poke;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [399:0] ans = '0;
    logic         busy;
    logic         digit_valid;
    logic         digit_ready = 1'b0;
    logic [3:0]   digit;
    logic [7:0]   digit_idx;
    logic         last;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [399:0] E_ANS = {8'd2, 64'hB7E1_5162_8AED_2A6A, 328'd0};
    localparam logic [51:0]  E_HAND = {4'd2, 4'd7, 4'd1, 4'd8, 4'd2, 4'd8, 4'd1,
                                       4'd8, 4'd2, 4'd8, 4'd4, 4'd5, 4'd9};

    e_digit_stream #(.NDIGITS(NDIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ans        (ans),
        .busy       (busy),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .digit      (digit),
        .digit_idx  (digit_idx),
        .last       (last),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(digit_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_last"},  32'(last), 0);
        check({tag, "_digit"}, 32'(digit), 0);
        check({tag, "_idx"},   32'(digit_idx), 0);
    endtask

    // Issues one start, then follows the stream cycle by cycle against the reference model.
    task automatic run_vec(input vec_t v);
        logic [391:0] m;
        logic [395:0] t;
        logic [51:0]  h;
        logic [3:0]   exp_d;
        int           k;
        int           cyc;
        int           vcnt;
        bit           rdy;
        m    = v.ans[391:0];
        h    = v.hand;
        t    = '0;
        k    = 0;
        cyc  = 0;
        vcnt = 0;
        @(negedge clk);
        ans   = v.ans;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.exp_err) begin
            check("err_valid", 32'(digit_valid), 0);
            check("err_done",  32'(done), 1);
            check("err_flag",  32'(err), 1);
            check("err_busy",  32'(busy), 0);
            @(negedge clk);
            check("err_done_pulse", 32'(done), 0);
            check("err_hold",       32'(err), 1);
            repeat (3) @(negedge clk);
            check("err_hold_idle", 32'(err), 1);
            check("err_no_valid",  32'(digit_valid), 0);
            return;
        end
        check("err_clear",   32'(err), 0);
        check("first_valid", 32'(digit_valid), 1);
        check("busy_emit",   32'(busy), 1);
        while (k <= NDIGITS && cyc < BUDGET) begin
            rdy = 1'b1;
            if (v.bp) rdy = (cyc >= 20 && cyc < 60) ? 1'b0 : ($urandom_range(0, 9) < 4);
            digit_ready = rdy;
            if (v.poke) begin
                start = (cyc == 5);
                ans   = {8'd3, ~v.ans[391:0]};
            end
            if (k == 0) begin
                exp_d = v.ans[395:392];
            end else begin
                t     = {4'b0, m} * 10;
                exp_d = t[395:392];
            end
            check($sformatf("valid[%0d]", k), 32'(digit_valid), 1);
            check($sformatf("digit[%0d]", k), 32'(digit), 32'(exp_d));
            check($sformatf("idx[%0d]", k),   32'(digit_idx), k);
            check($sformatf("last[%0d]", k),  32'(last), 32'(k == NDIGITS));
            if (k < 13) check($sformatf("hand[%0d]", k), 32'(digit), 32'(h[51-4*k -: 4]));
            if (digit_valid) vcnt++;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (k > 0) m = t[391:0];
                k++;
            end
        end
        digit_ready = 1'b0;
        start       = 1'b0;
        check("cycle_budget", 32'(cyc < BUDGET), 1);
        if (!v.bp && !v.poke) check("valid_cycles", vcnt, NDIGITS + 1);
        check("done_fin",  32'(done), 1);
        check("busy_fin",  32'(busy), 0);
        check("valid_fin", 32'(digit_valid), 0);
        // A start landing on the done cycle must not launch a new stream.
        if (v.poke) begin
            start = 1'b1;
            ans   = E_ANS;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse",  32'(done), 0);
        check("idle_valid",  32'(digit_valid), 0);
        check("idle_busy",   32'(busy), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int waited;
        vecs[0]  = '{ {8'd2, 1'b1, 391'd0},   {4'd2, 4'd5, 44'd0},         1'b0, 1'b0, 1'b0 };
        vecs[1]  = '{ E_ANS,                  E_HAND,                      1'b0, 1'b0, 1'b0 };
        vecs[2]  = '{ 400'd0,                 52'd0,                       1'b0, 1'b0, 1'b0 };
        vecs[3]  = '{ {8'd9, {392{1'b1}}},    {13{4'd9}},                  1'b0, 1'b0, 1'b0 };
        vecs[4]  = '{ {8'd0, 2'b01, 390'd0},  {4'd0, 4'd2, 4'd5, 40'd0},   1'b0, 1'b0, 1'b0 };
        vecs[5]  = '{ {8'd1, 3'b001, 389'd0}, {4'd1, 4'd1, 4'd2, 4'd5, 36'd0}, 1'b0, 1'b1, 1'b0 };
        vecs[6]  = '{ E_ANS,                  E_HAND,                      1'b0, 1'b1, 1'b0 };
        vecs[7]  = '{ E_ANS,                  E_HAND,                      1'b0, 1'b0, 1'b1 };
        vecs[8]  = '{ {8'd10, 392'd5},        52'd0,                       1'b1, 1'b0, 1'b0 };
        vecs[9]  = '{ {8'd255, {392{1'b1}}},  52'd0,                       1'b1, 1'b0, 1'b0 };
        vecs[10] = '{ E_ANS,                  E_HAND,                      1'b0, 1'b0, 1'b0 };

        // Reset held with start and ready asserted: reset must win.
        start       = 1'b1;
        digit_ready = 1'b1;
        ans         = E_ANS;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        start       = 1'b0;
        digit_ready = 1'b0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        check("por_no_stream", 32'(digit_valid), 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset in the middle of a stream, coincident with start and ready.
        @(negedge clk);
        ans         = E_ANS;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        digit_ready = 1'b1;
        waited      = 0;
        while (digit_idx != 8'd5 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reached_idx5", 32'(digit_idx), 5);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst         = 1'b1;
        start       = 1'b0;
        digit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_valid", 32'(digit_valid), 0);
        check("post_rst_busy",  32'(busy), 0);
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
